rgb_word_packer: RTL



---
 rtl/rgb_pack_pkg.sv | 15 +
 rtl/rgb_pack_fifo.sv | 56 +++++
 rtl/rgb_word_packer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rgb_pack_pkg.sv
// Shared types and constants for the RGB888 -> 32-bit word packer.
package rgb_pack_pkg;
  localparam int PIX_PER_GROUP   = 4;
  localparam int WORDS_PER_GROUP = 3;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} pack_phase_t;

  typedef struct packed {
    logic [8*BYTES_PER_WORD-1:0] data;
    logic                        sof;
    logic                        eol;
    logic                        eof;
  } pack_entry_t;
endpackage

// File: rtl/rgb_pack_fifo.sv
// Synchronous FIFO of pack_entry_t; head entry is read straight out of storage.
module rgb_pack_fifo
  import rgb_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  pack_entry_t                   i_entry,
  input  logic                          i_pop,
  output pack_entry_t                   o_head,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  pack_entry_t       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push, w_pop;

  assign w_push  = i_push && (r_cnt != CW'(FIFO_DEPTH));
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_valid = (r_cnt != '0);
  assign o_count = r_cnt;
  // Gate with valid so the outputs read zero when empty, including out of reset.
  assign o_head  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/rgb_word_packer.sv
// Packs RGB888 pixels, 4 per group, into 3 tagged 32-bit words through a small FIFO.
// Optional RGB_PACKER_FRAME_CNT_EN adds a 16-bit count of popped end-of-frame words.
module rgb_word_packer
  import rgb_pack_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        pix_sof,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_sof,
  output logic        word_eol,
  output logic        word_eof,
  output logic        err_resync
`ifdef RGB_PACKER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  generate
    if (IMG_WIDTH % PIX_PER_GROUP != 0 || IMG_WIDTH < PIX_PER_GROUP) begin : g_bad_width
      $error("IMG_WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  pack_phase_t     r_phase, w_ph_eff, w_ph_nxt;
  logic [XW-1:0]   r_x, w_x_eff, w_x_nxt;
  logic [YW-1:0]   r_y, w_y_eff, w_y_nxt;
  logic [7:0]      r_r0, r_g0, r_b0, r_g1, r_b1, r_b2;
  logic            r_err, w_err_nxt;
  logic            w_accept, w_pop, w_push, w_last_x, w_last_y;
  pack_entry_t     w_entry, w_head;
  logic [CW-1:0]   w_count;

  assign w_accept  = pix_valid & pix_ready;
  assign w_pop     = word_valid & word_ready;
  assign pix_ready = (w_count < CW'(FIFO_DEPTH));

  // A start-of-frame pixel is always handled as pixel (0,0), whatever the counters say.
  assign w_ph_eff  = pix_sof ? PH0 : r_phase;
  assign w_x_eff   = pix_sof ? '0  : r_x;
  assign w_y_eff   = pix_sof ? '0  : r_y;
  assign w_last_x  = (w_x_eff == XW'(IMG_WIDTH - 1));
  assign w_last_y  = (w_y_eff == YW'(IMG_HEIGHT - 1));

  always_comb begin
    w_ph_nxt  = r_phase;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    w_entry   = '0;
    if (w_accept) begin
      w_ph_nxt = pack_phase_t'(w_ph_eff + 2'd1);
      w_x_nxt  = w_last_x ? '0 : w_x_eff + XW'(1);
      if (w_last_x) w_y_nxt = w_last_y ? '0 : w_y_eff + YW'(1);
      else          w_y_nxt = w_y_eff;
      if (pix_sof && (r_phase != PH0 || r_x != '0 || r_y != '0)) w_err_nxt = 1'b1;
      case (w_ph_eff)
        PH1: begin
          w_push       = 1'b1;
          w_entry.data = {R_in, r_b0, r_g0, r_r0};
          w_entry.sof  = (w_y_eff == '0) && (w_x_eff == XW'(1));
        end
        PH2: begin
          w_push       = 1'b1;
          w_entry.data = {G_in, R_in, r_b1, r_g1};
        end
        PH3: begin
          w_push       = 1'b1;
          w_entry.data = {B_in, G_in, R_in, r_b2};
          w_entry.eol  = w_last_x;
          w_entry.eof  = w_last_x & w_last_y;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH0;
      r_x     <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_phase <= w_ph_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Leftover bytes only matter once a later pixel completes their word, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      case (w_ph_eff)
        PH0: begin r_r0 <= R_in; r_g0 <= G_in; r_b0 <= B_in; end
        PH1: begin r_g1 <= G_in; r_b1 <= B_in; end
        PH2: r_b2 <= B_in;
        default: ;
      endcase
    end
  end

  rgb_pack_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (word_valid),
    .o_count (w_count)
  );

  assign word_data  = w_head.data;
  assign word_sof   = w_head.sof;
  assign word_eol   = w_head.eol;
  assign word_eof   = w_head.eof;
  assign err_resync = r_err;

`ifdef RGB_PACKER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk) begin
    if (rst)                   r_frame_cnt <= '0;
    else if (w_pop & word_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign frame_cnt = r_frame_cnt;
`endif
endmodule
